// File: rtl/da_pkg.sv
// Shared definitions for the bit-serial distributed-arithmetic FIR:
// state encoding, default widths and the three tap coefficients.
package da_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } da_state_e;

    localparam int DA_W  = 8;
    localparam int DA_YW = 12;

    // y[n] = DA_C0*x[n] + DA_C1*x[n-1] + DA_C2*x[n-2]
    localparam int DA_C0 = 2;
    localparam int DA_C1 = 3;
    localparam int DA_C2 = 1;

endpackage

// File: rtl/da_lut3.sv
// Distributed-arithmetic table: sum of the coefficients whose tap bit is set.
// Address bit 0 is the newest sample, bit 2 the oldest.
module da_lut3
    import da_pkg::*;
(
    input  logic [2:0] addr_i,
    output logic [2:0] lut_o
);

    always_comb begin
        lut_o = 3'd0;
        case (addr_i)
            3'd0: lut_o = 3'd0;
            3'd1: lut_o = 3'(DA_C0);
            3'd2: lut_o = 3'(DA_C1);
            3'd3: lut_o = 3'(DA_C0 + DA_C1);
            3'd4: lut_o = 3'(DA_C2);
            3'd5: lut_o = 3'(DA_C0 + DA_C2);
            3'd6: lut_o = 3'(DA_C1 + DA_C2);
            3'd7: lut_o = 3'(DA_C0 + DA_C1 + DA_C2);
            default: lut_o = 3'd0;
        endcase
    end

endmodule

// File: rtl/da_seq_ctrl.sv
// 3-tap FIR computed bit-serially, MSB plane first, one bit plane per clock.
// Accept in IDLE, W cycles of RUN, then HOLD the result until consumed.
module da_seq_ctrl
    import da_pkg::*;
#(
    parameter int W  = DA_W,
    parameter int YW = DA_YW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [W-1:0]  x_in,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic signed [YW-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    da_state_e           state_q;
    logic [W-1:0]        d0_q, d1_q, d2_q;
    logic signed [YW-1:0] acc_q, acc_d, y_q;
    logic [CW-1:0]       cnt_q;
    logic                x_ready_q, y_valid_q, busy_q;

    logic [2:0]          lut_addr;
    logic [2:0]          lut_val;
    logic signed [YW-1:0] lut_ext, acc_sh;

    assign lut_addr = {d2_q[cnt_q], d1_q[cnt_q], d0_q[cnt_q]};

    da_lut3 u_lut (
        .addr_i (lut_addr),
        .lut_o  (lut_val)
    );

    // The sign plane carries negative weight in two's complement.
    always_comb begin
        lut_ext = YW'(lut_val);
        acc_sh  = acc_q << 1;
        acc_d   = (cnt_q == CW'(W - 1)) ? (acc_sh - lut_ext) : (acc_sh + lut_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            x_ready_q <= 1'b1;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (x_valid) begin
                        d2_q      <= d1_q;
                        d1_q      <= d0_q;
                        d0_q      <= x_in;
                        acc_q     <= '0;
                        cnt_q     <= CW'(W - 1);
                        state_q   <= RUN;
                        x_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        y_q       <= acc_d;
                        state_q   <= HOLD;
                        busy_q    <= 1'b0;
                        y_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (y_ready) begin
                        state_q   <= IDLE;
                        y_valid_q <= 1'b0;
                        x_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    x_ready_q <= 1'b1;
                    y_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign x_ready = x_ready_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;
    assign y       = y_q;

endmodule

// File: tb/tb_da_seq_ctrl.sv
// Self-checking bench for da_seq_ctrl against a plain-arithmetic FIR model.
module tb_da_seq_ctrl;

    localparam int W  = 8;
    localparam int YW = 12;

    logic                 clk;
    logic                 reset;
    logic signed [W-1:0]  x_in;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [YW-1:0] y;
    logic                 y_valid;
    logic                 y_ready;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;
    int dl[3];

    da_seq_ctrl #(.W(W), .YW(YW)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_in    (x_in),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_push(input int x);
        dl[2] = dl[1];
        dl[1] = dl[0];
        dl[0] = x;
        return 2 * dl[0] + 3 * dl[1] + 1 * dl[2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dl = '{0, 0, 0};
        chk("rst_x_ready", int'(x_ready), 1);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_y", int'(y), 0);
    endtask

    // Accept one sample, wait for its result, compare, then leave it in HOLD.
    task automatic send_wait(input int x, output int yv);
        int n;
        int exp;
        n = 0;
        while (!x_ready && n < 50) begin tick(); n++; end
        chk("pre_x_ready", int'(x_ready), 1);
        x_in    = W'(x);
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        exp = ref_push(x);
        chk("acc_busy", int'(busy), 1);
        chk("acc_x_ready", int'(x_ready), 0);
        n = 0;
        while (!y_valid && n < 50) begin tick(); n++; end
        chk("latency", n, W);
        yv = int'(y);
        chk("y_model", yv, exp);
    endtask

    task automatic consume();
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk("drain_y_valid", int'(y_valid), 0);
        chk("drain_x_ready", int'(x_ready), 1);
    endtask

    task automatic send(input int x, input int exp_const, input string tag);
        int yv;
        send_wait(x, yv);
        chk(tag, yv, exp_const);
        consume();
    endtask

    initial begin
        int yv, yhold, seen, n, nacc, last_acc, cyc, nres;
        int q[$];
        logic acc_now;

        reset = 1'b0; x_in = '0; x_valid = 1'b0; y_ready = 1'b0;
        dl = '{0, 0, 0};
        tick();
        do_reset();

        // impulse
        send(1, 2, "imp0");
        send(0, 3, "imp1");
        send(0, 1, "imp2");

        // negative full scale
        send(-128, -256, "neg0");
        send(0, -384, "neg1");
        send(0, -128, "neg2");
        send(-128, -256, "negfs0");
        send(-128, -640, "negfs1");
        send(-128, -768, "negfs2");

        // positive full scale and mixed
        send(127, -258, "pos0");
        send(127, 507, "pos1");
        send(127, 762, "pos2");
        send(-128, 252, "mixed");

        // back-pressure: HOLD ignores x_valid while y_ready is low
        send_wait($urandom_range(0, 255) - 128, yhold);
        x_valid = 1'b1;
        x_in    = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_y_valid", int'(y_valid), 1);
            chk("bp_y", int'(y), yhold);
            chk("bp_x_ready", int'(x_ready), 0);
        end
        x_valid = 1'b0;
        consume();
        // delay line must not contain the ignored sample
        n = $urandom_range(0, 255) - 128;
        send_wait(n, yv);
        consume();

        // reset mid-RUN at counter = 4
        x_in = W'(100); x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        seen = 0;
        repeat (3) begin tick(); if (y_valid) seen++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dl = '{0, 0, 0};
        repeat (12) begin tick(); if (y_valid) seen++; end
        chk("rst_run_no_yv", seen, 0);
        chk("rst_run_x_ready", int'(x_ready), 1);
        send(1, 2, "after_rst");

        // streaming with both handshakes tied high
        x_valid = 1'b1; y_ready = 1'b1;
        x_in = W'($urandom);
        nacc = 0; nres = 0; last_acc = -1; cyc = 0;
        while (nres < 10 && cyc < 300) begin
            acc_now = x_ready && x_valid;
            tick();
            cyc++;
            if (acc_now) begin
                q.push_back(ref_push(int'(x_in)));
                if (last_acc >= 0) chk("stream_interval", cyc - last_acc, W + 2);
                last_acc = cyc;
                nacc++;
                x_in = W'($urandom);
                if (nacc >= 10) x_valid = 1'b0;
            end
            if (y_valid) begin
                if (q.size() == 0) chk("stream_spurious", 1, 0);
                else chk("stream_y", int'(y), q.pop_front());
                nres++;
            end
        end
        chk("stream_results", nres, 10);
        x_valid = 1'b0; y_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
